// File: rtl/obsidian_operand_fetch.sv
// obsidian_operand_fetch: register-file initiator with busy scoreboard, hazard stall and operand handshake
module obsidian_operand_fetch #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [ADDR_W-1:0]  instr_rm,
    input  logic [ADDR_W-1:0]  instr_rn,
    input  logic [ADDR_W-1:0]  instr_rd,
    input  logic               instr_wr,
    output logic [ADDR_W-1:0]  rm_control,
    output logic [ADDR_W-1:0]  rn_control,
    input  logic [DATA_W-1:0]  rm_data,
    input  logic [DATA_W-1:0]  rn_data,
    output logic [ADDR_W-1:0]  rd_control,
    output logic [DATA_W-1:0]  rd_input,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [DATA_W-1:0]  op_a,
    output logic [DATA_W-1:0]  op_b,
    output logic [ADDR_W-1:0]  op_rd,
    output logic               op_wr,
    input  logic               wb_valid,
    input  logic [ADDR_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               wb_err,
    output logic [STALL_W-1:0] stall_count
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CAP, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic [ADDR_W-1:0]   lat_rd_q;
    logic                lat_wr_q;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                hazard, accept, wb_fire;

    // r0 is hardwired zero, so it never creates a dependency
    assign hazard  = (busy_q[instr_rm] && instr_rm != '0) ||
                     (busy_q[instr_rn] && instr_rn != '0) ||
                     (instr_wr && instr_rd != '0 && busy_q[instr_rd]);
    assign accept  = instr_valid && instr_ready;
    assign wb_fire = wb_valid && wb_rd != '0;
    assign stall_count = stall_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state: read address settles, data captured, then held until execute takes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_READ : S_IDLE;
            S_READ:  state_d = S_CAP;
            S_CAP:   state_d = S_OUT;
            S_OUT:   state_d = op_ready ? S_IDLE : S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    // output: only accept in idle with no outstanding dependency, never during reset
    always_comb instr_ready = rst_n && state_q == S_IDLE && !hazard;

    // busy next-state: clear on writeback, set on accepted writer (WAW check keeps them disjoint)
    always_comb begin
        busy_d = busy_q;
        if (wb_fire) busy_d[wb_rd] = 1'b0;
        if (accept && instr_wr && instr_rd != '0) busy_d[instr_rd] = 1'b1;
    end

    // saturating count of cycles an offered instruction waits on a hazard
    always_comb stall_d = (instr_valid && state_q == S_IDLE && hazard && stall_q != '1)
                          ? stall_q + STALL_W'(1) : stall_q;

    // read addresses, operand capture and execute handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rm_control <= '0;
            rn_control <= '0;
            lat_rd_q   <= '0;
            lat_wr_q   <= 1'b0;
            op_valid   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_rd      <= '0;
            op_wr      <= 1'b0;
        end else begin
            if (accept) begin
                rm_control <= instr_rm;
                rn_control <= instr_rn;
                lat_rd_q   <= instr_rd;
                lat_wr_q   <= instr_wr;
            end
            if (state_q == S_CAP) begin
                op_a     <= rm_data;
                op_b     <= rn_data;
                op_rd    <= lat_rd_q;
                op_wr    <= lat_wr_q;
                op_valid <= 1'b1;
            end else if (state_q == S_OUT && op_ready) begin
                op_valid <= 1'b0;
            end
        end
    end

    // write port, busy scoreboard, error pulse and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_control <= '0;
            rd_input   <= '0;
            busy_q     <= '0;
            wb_err     <= 1'b0;
            stall_q    <= '0;
        end else begin
            if (wb_fire) begin
                rd_control <= wb_rd;
                rd_input   <= wb_data;
            end
            busy_q  <= busy_d;
            wb_err  <= wb_fire && !busy_q[wb_rd];
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_obsidian_operand_fetch.sv
// tb_obsidian_operand_fetch: scoreboard bench with register-file model and random issue/writeback traffic
module tb_obsidian_operand_fetch;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid, instr_ready, instr_wr;
    logic [AW-1:0] instr_rm, instr_rn, instr_rd;
    logic [AW-1:0] rm_control, rn_control, rd_control;
    logic [DW-1:0] rm_data = '0, rn_data = '0, rd_input;
    logic          op_valid, op_ready, op_wr;
    logic [DW-1:0] op_a, op_b;
    logic [AW-1:0] op_rd;
    logic          wb_valid, wb_err;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [SW-1:0] stall_count;

    obsidian_operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .STALL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_rm(instr_rm), .instr_rn(instr_rn), .instr_rd(instr_rd), .instr_wr(instr_wr),
        .rm_control(rm_control), .rn_control(rn_control),
        .rm_data(rm_data), .rn_data(rn_data),
        .rd_control(rd_control), .rd_input(rd_input),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr(op_wr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_err(wb_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // register file: registered reads on posedge, unconditional write on negedge
    logic [DW-1:0] rf [32] = '{default: '0};
    always @(negedge clk) rf[rd_control] <= rd_input;
    always @(posedge clk) begin
        rm_data <= rf[rm_control];
        rn_data <= rf[rn_control];
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          wr;
    } op_t;

    op_t           sbq[$];
    logic [DW-1:0] mregs [32];
    bit            mbusy [32];
    bit            midle;
    int            mstall;
    logic [AW-1:0] exp_rdc;
    logic [DW-1:0] exp_rdi;
    int            n_chk = 0;
    int            n_fail = 0;
    int            ready_mode = 0;
    bit            done = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hz();
        return (mbusy[instr_rm] && instr_rm != 0) || (mbusy[instr_rn] && instr_rn != 0) ||
               (instr_wr && instr_rd != 0 && mbusy[instr_rd]);
    endfunction

    function automatic int pick_busy();
        int c[$];
        for (int i = 1; i < 32; i++) if (mbusy[i]) c.push_back(i);
        return c.size() == 0 ? -1 : c[$urandom_range(0, c.size() - 1)];
    endfunction

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // offer an instruction until accepted; expected operands are the architectural values at accept
    task automatic issue(input logic [AW-1:0] rm, input logic [AW-1:0] rn, input logic [AW-1:0] rd, input bit wr);
        int c;
        c = 0;
        instr_rm = rm; instr_rn = rn; instr_rd = rd; instr_wr = wr; instr_valid = 1'b1;
        forever begin
            #1;
            chk("instr_ready", 32'(instr_ready), 32'(midle && !hz()));
            chk("stall_count", 32'(stall_count), 32'(mstall));
            if (instr_ready) begin
                sbq.push_back('{mregs[rm], mregs[rn], rd, wr});
                if (wr && rd != 0) mbusy[rd] = 1'b1;
                midle = 1'b0;
                step();
                instr_valid = 1'b0; instr_rm = '0; instr_rn = '0; instr_rd = '0; instr_wr = 1'b0;
                return;
            end
            if (midle && hz() && mstall < 65535) mstall++;
            if (++c > 300) begin
                n_chk++; n_fail++;
                $display("FAIL issue_timeout: rm=%0d rn=%0d rd=%0d not accepted", rm, rn, rd);
                instr_valid = 1'b0;
                step();
                return;
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_wb(input logic [AW-1:0] r, input logic [DW-1:0] d);
        bit e;
        e = (r != 0) && !mbusy[r];
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        if (r != 0) begin
            mregs[r] = d; mbusy[r] = 1'b0; exp_rdc = r; exp_rdi = d;
        end
        chk("wb_err", 32'(wb_err), 32'(e));
        chk("rd_control", 32'(rd_control), 32'(exp_rdc));
        chk("rd_input", rd_input, exp_rdi);
    endtask

    task automatic wb(input logic [AW-1:0] r, input logic [DW-1:0] d);
        do_wb(r, d);
        #2;
    endtask

    // execute side back-pressure
    initial forever begin
        @(posedge clk);
        #1;
        op_ready = ready_mode == 2 ? ($urandom_range(0, 2) != 0) : (ready_mode == 1);
    end

    // monitor: every cycle with op_valid must match the oldest expected operand pair
    initial forever begin
        @(negedge clk);
        if (op_valid) begin
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL op_unexpected: op_valid=1 with a=0x%0h, expected no operand", op_a);
            end else begin
                chk("op_a", op_a, sbq[0].a);
                chk("op_b", op_b, sbq[0].b);
                chk("op_rd", 32'(op_rd), 32'(sbq[0].rd));
                chk("op_wr", 32'(op_wr), 32'(sbq[0].wr));
                if (op_ready) begin
                    void'(sbq.pop_front());
                    midle = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        instr_valid = 0; instr_rm = 0; instr_rn = 0; instr_rd = 0; instr_wr = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0; op_ready = 0;
        for (int i = 0; i < 32; i++) begin mregs[i] = '0; mbusy[i] = 0; end
        midle = 1; mstall = 0; exp_rdc = '0; exp_rdi = '0;
        repeat (2) step();
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_instr_ready", 32'(instr_ready), 0);
        chk("rst_stall", 32'(stall_count), 0);
        chk("rst_rd_control", 32'(rd_control), 0);
        chk("rst_op_a", op_a, 0);
        rst_n = 1;
        step();
        wb(0, 32'hBEEF);
        wb(3, 32'h11);
        wb(4, 32'h22);
        ready_mode = 0;
        issue(3, 4, 5, 1);
        chk("lat_t0", 32'(op_valid), 0);
        step();
        chk("lat_t1", 32'(op_valid), 0);
        step();
        chk("lat_t2", 32'(op_valid), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 32'(op_valid), 1);
            chk("hold_ready", 32'(instr_ready), 0);
            chk("hold_op_a", op_a, 32'h11);
        end
        ready_mode = 1;
        step();
        chk("rel_valid_held", 32'(op_valid), 1);
        step();
        chk("rel_valid_drop", 32'(op_valid), 0);
        chk("rel_ready", 32'(instr_ready), 1);
        fork
            issue(5, 0, 6, 0);
            begin repeat (4) step(); do_wb(5, 32'hDEAD); end
        join
        issue(1, 2, 5, 1);
        fork
            issue(0, 0, 5, 1);
            begin repeat (3) step(); do_wb(5, 32'h5A5A); end
        join
        repeat (4) step();
        wb(5, 32'h1234);
        issue(0, 0, 0, 1);
        wb(7, 32'h77);
        step();
        chk("wb_err_pulse", 32'(wb_err), 0);
        issue(7, 3, 8, 0);
        repeat (6) step();
        issue(1, 2, 9, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(op_valid), 0);
        chk("mid_rst_stall", 32'(stall_count), 0);
        chk("mid_rst_ready", 32'(instr_ready), 0);
        sbq.delete();
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
        midle = 1; mstall = 0; exp_rdc = '0; exp_rdi = '0;
        chk("mid_rst_rd_control", 32'(rd_control), 0);
        step();
        rst_n = 1;
        repeat (6) step();
        issue(9, 9, 9, 1);
        ready_mode = 2;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                done = 1;
            end
            begin
                int r;
                @(posedge clk);
                #2;
                while (!done) begin
                    r = pick_busy();
                    if (r > 0 && $urandom_range(0, 2) == 0) begin
                        do_wb(5'(r), $urandom);
                        #1;
                    end else begin
                        @(posedge clk);
                        #2;
                    end
                end
            end
        join
        for (int i = 1; i < 32; i++) if (mbusy[i]) do_wb(5'(i), $urandom);
        step();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) step();
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
